// File: rtl/ro_pkg.sv
// rtl/ro_pkg.sv - shared types and constants for the instrumented ring oscillator tile
//
// Purpose: control-field layout of ui_in, readout selectors, status bit
//          positions, and gate/prescale shift constants.
// Ports:   none (package).
`timescale 1ns/1ps
package ro_pkg;

  localparam int CNT_W = 24;

  // Gate window is 2^(GATE_BASE_SH + GATE_STEP_SH*gsel) clk cycles.
  localparam int GATE_BASE_SH = 8;
  localparam int GATE_STEP_SH = 4;
  localparam int WIN_W        = GATE_BASE_SH + 3 * GATE_STEP_SH;

  // Prescaler taps divide by 2^(PRE_STEP_SH*psel).
  localparam int PRE_STEP_SH = 4;
  localparam int PRE_BITS    = 3 * PRE_STEP_SH;

  localparam logic [7:0] UIO_OE_VAL = 8'b0000_0010;

  localparam int ST_VALID   = 7;
  localparam int ST_OSC_EN  = 6;
  localparam int ST_SRC_SEL = 5;

  typedef enum logic [1:0] {
    BSEL_B0     = 2'd0,
    BSEL_B1     = 2'd1,
    BSEL_B2     = 2'd2,
    BSEL_STATUS = 2'd3
  } bsel_e;

  typedef struct packed {
    bsel_e      bsel;
    logic [1:0] gsel;
    logic [1:0] psel;
    logic       src_sel;
    logic       osc_en;
  } ctrl_t;

  // Terminal value of the window counter for a given gate select.
  function automatic logic [WIN_W-1:0] gate_last(input logic [1:0] gsel);
    gate_last = WIN_W'((1 << (GATE_BASE_SH + GATE_STEP_SH * int'(gsel))) - 1);
  endfunction

endpackage

// File: rtl/ring_osc.sv
// rtl/ring_osc.sv - enable-gated ring oscillator
//
// Purpose: NAND enable stage followed by RING_STAGES-1 inverters. In
//          simulation a behavioural model toggles every SIM_HALF_PS while
//          enabled, since a zero-delay loop cannot oscillate.
// Ports:   osc_en   in  1  run enable (0 holds the ring static)
//          ring_out out 1  ring tap
`timescale 1ns/1ps
module ring_osc #(
  parameter int RING_STAGES = 7,
  parameter int SIM_HALF_PS = 500
) (
  input  logic osc_en,
  output logic ring_out
);
  import ro_pkg::*;

`ifndef SYNTHESIS
  // Level the real chain settles to when disabled: NAND drives 1, then an
  // even number of inverters.
  localparam logic IDLE_LVL = ((RING_STAGES - 1) % 2) == 0;

  logic ring_q = 1'b0;

  always begin
    if (osc_en) begin
      #(SIM_HALF_PS * 1ps);
      ring_q = ~ring_q;
    end else begin
      @(osc_en);
    end
  end

  assign ring_out = osc_en ? ring_q : IDLE_LVL;
`else
  (* keep, dont_touch = "true" *) logic [RING_STAGES-1:0] stage;

  assign stage[0] = ~(osc_en & stage[RING_STAGES-1]);
  for (genvar i = 1; i < RING_STAGES; i++) begin : g_inv
    assign stage[i] = ~stage[i-1];
  end
  assign ring_out = stage[RING_STAGES-1];
`endif

endmodule

// File: rtl/instrumented_ring_oscillator_two.sv
// rtl/instrumented_ring_oscillator_two.sv - ring oscillator with on-chip frequency counter
//
// Purpose: selects ring or external source, prescales it with a ripple
//          divider, synchronises into clk and counts rising edges over a
//          programmable gate window; result read out a byte at a time.
// Ports:   clk      in  1  system clock
//          rst_n    in  1  asynchronous active-low reset
//          ena      in  1  tile select (unused)
//          ui_in    in  8  {bsel, gsel, psel, src_sel, osc_en}
//          uo_out   out 8  readout byte selected by bsel
//          uio_in   in  8  [0] external test source
//          uio_out  out 8  [1] prescaled source tap
//          uio_oe   out 8  constant 8'h02
`timescale 1ns/1ps
module instrumented_ring_oscillator_two #(
  parameter int RING_STAGES = 7,
  parameter int CNT_W       = ro_pkg::CNT_W,
  parameter int SIM_HALF_PS = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import ro_pkg::*;

  ctrl_t ctrl;
  assign ctrl = ctrl_t'(ui_in);

  logic ring_out;
  logic src;
  logic pre;

  ring_osc #(
    .RING_STAGES(RING_STAGES),
    .SIM_HALF_PS(SIM_HALF_PS)
  ) u_ring (
    .osc_en  (ctrl.osc_en),
    .ring_out(ring_out)
  );

  assign src = ctrl.src_sel ? uio_in[0] : ring_out;

  // Ripple divider: each stage is clocked by the falling edge of the one
  // before it, so the source can run far faster than clk.
  logic [PRE_BITS-1:0] div;

  for (genvar i = 0; i < PRE_BITS; i++) begin : g_div
    logic q;
    if (i == 0) begin : g_first
      always_ff @(posedge src or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else        q <= ~q;
      end
    end else begin : g_rest
      always_ff @(negedge div[i-1] or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else        q <= ~q;
      end
    end
    assign div[i] = q;
  end

  always_comb begin
    pre = src;
    case (ctrl.psel)
      2'd0:    pre = src;
      2'd1:    pre = div[PRE_STEP_SH-1];
      2'd2:    pre = div[2*PRE_STEP_SH-1];
      default: pre = div[3*PRE_STEP_SH-1];
    endcase
  end

  // Two-flop synchroniser plus edge register.
  logic s1, s2, s3;
  logic rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {s1, s2, s3} <= 3'b000;
    else        {s1, s2, s3} <= {pre, s1, s2};
  end

  assign rise = s2 & ~s3;

  // Gate select is latched on the first cycle of each window; on that
  // cycle the live input is used so the new length applies immediately.
  logic [WIN_W-1:0] win_cnt;
  logic [1:0]       gsel_q;
  logic [1:0]       gsel_eff;
  logic             win_last;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_next;
  logic [CNT_W-1:0] result;
  logic             valid;
  logic [3:0]       seq;

  assign gsel_eff  = (win_cnt == '0) ? ctrl.gsel : gsel_q;
  assign win_last  = (win_cnt == gate_last(gsel_eff));
  assign edge_next = (&edge_cnt) ? edge_cnt : edge_cnt + CNT_W'(rise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      gsel_q   <= '0;
      edge_cnt <= '0;
      result   <= '0;
      valid    <= 1'b0;
      seq      <= '0;
    end else begin
      if (win_cnt == '0) gsel_q <= ctrl.gsel;
      if (win_last) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
        result   <= edge_next;
        valid    <= 1'b1;
        seq      <= seq + 4'd1;
      end else begin
        win_cnt  <= win_cnt + WIN_W'(1);
        edge_cnt <= edge_next;
      end
    end
  end

  logic [23:0] res24;
  logic [7:0]  status;

  assign res24 = 24'(result);

  always_comb begin
    status             = {4'b0000, seq};
    status[ST_VALID]   = valid;
    status[ST_OSC_EN]  = ctrl.osc_en;
    status[ST_SRC_SEL] = ctrl.src_sel;
  end

  always_comb begin
    uo_out = 8'h00;
    case (ctrl.bsel)
      BSEL_B0:     uo_out = res24[7:0];
      BSEL_B1:     uo_out = res24[15:8];
      BSEL_B2:     uo_out = res24[23:16];
      BSEL_STATUS: uo_out = status;
      default:     uo_out = 8'h00;
    endcase
  end

  assign uio_out = {6'b000000, pre, 1'b0};
  assign uio_oe  = UIO_OE_VAL;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:1]};

endmodule

// File: tb/tb_instrumented_ring_oscillator_two.sv
// tb/tb_instrumented_ring_oscillator_two.sv - directed self-checking bench for the ring oscillator tile
`timescale 1ns/1ps
module tb_instrumented_ring_oscillator_two;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic ext_wave = 1'b0;
  int   ext_half = 0;
  int   ext_cnt  = 0;
  int   total = 0;
  int   bad   = 0;

  assign uio_in = {7'b0000000, ext_wave};

  instrumented_ring_oscillator_two dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  // External square wave: toggles every ext_half clk cycles.
  always @(negedge clk) begin
    if (ext_half != 0) begin
      ext_cnt = ext_cnt + 1;
      if (ext_cnt >= ext_half) begin
        ext_cnt  = 0;
        ext_wave = ~ext_wave;
      end
    end
  end

  function automatic logic [7:0] ctl(input logic osc, input logic src,
                                     input int psel, input int gsel, input int bsel);
    logic [1:0] p, g, b;
    p = 2'(psel);
    g = 2'(gsel);
    b = 2'(bsel);
    ctl = {b, g, p, src, osc};
  endfunction

  task automatic do_reset(input logic [7:0] u);
    @(negedge clk);
    rst_n = 1'b0;
    ui_in = u;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_seq(input logic [3:0] target, input int budget, input string name);
    int n;
    logic hit;
    ui_in[7:6] = 2'd3;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      if (uo_out[3:0] == target) hit = 1'b1;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: seq never reached %0d within %0d cycles (last status %h)",
               name, target, budget, uo_out);
    end
  endtask

  task automatic read_byte(input int b, output logic [7:0] v);
    ui_in[7:6] = 2'(b);
    #1;
    v = uo_out;
  endtask

  task automatic test_reset;
    ext_half = 0;
    ext_wave = 1'b0;
    rst_n = 1'b0;
    ui_in = ctl(1'b0, 1'b0, 1, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (uo_out !== 8'h00) begin bad++; $display("FAIL reset_uo_out: got %h expected 00", uo_out); end
    total++;
    if (uio_out !== 8'h00) begin bad++; $display("FAIL reset_uio_out: got %h expected 00", uio_out); end
    total++;
    if (uio_oe !== 8'h02) begin bad++; $display("FAIL reset_uio_oe: got %h expected 02", uio_oe); end
    @(negedge clk);
    rst_n = 1'b1;
    ui_in = ctl(1'b0, 1'b1, 1, 0, 3);
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (uo_out !== 8'h20) begin bad++; $display("FAIL reset_status: got %h expected 20", uo_out); end
  endtask

  task automatic test_ext_source;
    logic [7:0] b0, b1, b2, st;
    ext_half = 4;
    do_reset(ctl(1'b0, 1'b1, 0, 0, 3));
    wait_seq(4'd2, 700, "ext_wait");
    read_byte(0, b0);
    read_byte(1, b1);
    read_byte(2, b2);
    read_byte(3, st);
    total++;
    if (b0 < 8'd31 || b0 > 8'd33) begin bad++; $display("FAIL ext_byte0: got %0d expected 32+-1", b0); end
    total++;
    if (b1 !== 8'h00) begin bad++; $display("FAIL ext_byte1: got %0d expected 0", b1); end
    total++;
    if (b2 !== 8'h00) begin bad++; $display("FAIL ext_byte2: got %0d expected 0", b2); end
    total++;
    if (st !== 8'hA2) begin bad++; $display("FAIL ext_status: got %h expected a2", st); end
  endtask

  task automatic test_prescale;
    logic [7:0] b0, st;
    logic prev;
    int tog;
    ext_half = 1;
    do_reset(ctl(1'b0, 1'b1, 1, 0, 0));
    repeat (8) @(posedge clk);
    #1;
    prev = uio_out[1];
    tog = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (uio_out[1] != prev) tog++;
      prev = uio_out[1];
    end
    total++;
    if (tog < 3 || tog > 5) begin bad++; $display("FAIL pre_tap_toggles: got %0d expected 4+-1", tog); end
    wait_seq(4'd2, 700, "pre_wait");
    read_byte(0, b0);
    read_byte(3, st);
    total++;
    if (b0 < 8'd7 || b0 > 8'd9) begin bad++; $display("FAIL pre_byte0: got %0d expected 8+-1", b0); end
    total++;
    if (st !== 8'hA2) begin bad++; $display("FAIL pre_status: got %h expected a2", st); end
  endtask

  task automatic test_sequence;
    logic [7:0] st;
    wait_seq(4'd15, 14 * 256 + 200, "seq_wait15");
    read_byte(3, st);
    total++;
    if (st !== 8'hAF) begin bad++; $display("FAIL seq_at_15: got %h expected af", st); end
    wait_seq(4'd0, 400, "seq_wait_wrap");
    read_byte(3, st);
    total++;
    if (st !== 8'hA0) begin bad++; $display("FAIL seq_wrap: got %h expected a0", st); end
  endtask

  task automatic test_ring;
    logic [7:0] b0, b1, b2, st;
    ext_half = 0;
    ext_wave = 1'b0;
    do_reset(ctl(1'b0, 1'b0, 2, 0, 0));
    wait_seq(4'd2, 700, "ring_off_wait");
    read_byte(0, b0);
    read_byte(1, b1);
    read_byte(2, b2);
    total++;
    if ({b2, b1, b0} !== 24'h0) begin bad++; $display("FAIL ring_static: got %0d expected 0", {b2, b1, b0}); end
    ui_in = ctl(1'b1, 1'b0, 2, 0, 3);
    wait_seq(4'd4, 700, "ring_on_wait");
    read_byte(0, b0);
    read_byte(3, st);
    total++;
    if (b0 < 8'd9 || b0 > 8'd11) begin bad++; $display("FAIL ring_running: got %0d expected 10+-1", b0); end
    total++;
    if (st !== 8'hC4) begin bad++; $display("FAIL ring_status: got %h expected c4", st); end
    ui_in = ctl(1'b0, 1'b0, 2, 0, 0);
  endtask

  task automatic test_gate_change;
    int n, m;
    logic hit;
    ext_half = 4;
    @(negedge clk);
    rst_n = 1'b0;
    ui_in = ctl(1'b0, 1'b1, 0, 0, 3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 100) ui_in = ctl(1'b0, 1'b1, 0, 1, 3);
      #1;
      if (uo_out[3:0] == 4'd1) hit = 1'b1;
    end
    total++;
    if (n != 256) begin bad++; $display("FAIL gate_first_len: got %0d expected 256", n); end
    m = 0;
    hit = 1'b0;
    while (!hit && m < 5000) begin
      @(negedge clk);
      m++;
      #1;
      if (uo_out[3:0] == 4'd2) hit = 1'b1;
    end
    total++;
    if (m != 4096) begin bad++; $display("FAIL gate_second_len: got %0d expected 4096", m); end
  endtask

  initial begin
    test_reset();
    test_ext_source();
    test_prescale();
    test_sequence();
    test_ring();
    test_gate_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
